ctrl_debounce: RTL

Conditions a single asynchronous 1-bit control input (pushbutton, strap, external enable) into a clean, glitch-free, clock-synchronous level plus optional one-cycle edge pulses. It sits directly upstream of the 1-bit pass-through wire stage and drives that stage's `bit` input. Outputs change only after the input has held a new value for a programmable number of consecutive cycles.

---
 rtl/ctrl_pkg.sv | 6 +
 rtl/ctrl_sync.sv | 16 +
 rtl/ctrl_debounce.sv | 72 +++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state type and default parameters for the control-input conditioning blocks.
package ctrl_pkg;
    typedef enum logic {DB_IDLE, DB_PEND} db_state_t;
    localparam int CTRL_SYNC_STAGES_DEF   = 2;
    localparam int CTRL_STABLE_CYCLES_DEF = 16;
endpackage

// File: rtl/ctrl_sync.sv
// ctrl_sync: plain flop-chain synchronizer for one asynchronous bit, reset to RESET_LEVEL.
module ctrl_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r;
    always_ff @(posedge clk or posedge rst)
        if (rst) r <= {SYNC_STAGES{RESET_LEVEL}};
        else     r <= {r[SYNC_STAGES-2:0], d};
    assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/ctrl_debounce.sv
// ctrl_debounce: synchronizes and debounces a raw control bit into a clean level plus edge pulses.
// Edge pulses are built only when CTRL_DEBOUNCE_PULSE_EN is defined; otherwise rise/fall are tied low.
module ctrl_debounce
    import ctrl_pkg::*;
#(
    parameter int   SYNC_STAGES   = CTRL_SYNC_STAGES_DEF,
    parameter int   STABLE_CYCLES = CTRL_STABLE_CYCLES_DEF,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    logic          sync_q;
    logic          flip;
    db_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_raw),
        .q   (sync_q)
    );
    // cnt counts consecutive cycles sync_q has differed from out; any agreement restarts it
    always_comb begin
        state_d = DB_IDLE;
        cnt_d   = '0;
        flip    = 1'b0;
        if (sync_q != out) begin
            if (state == DB_IDLE && STABLE_CYCLES == 1)
                flip = 1'b1;
            else if (state == DB_IDLE) begin
                state_d = DB_PEND;
                cnt_d   = CW'(1);
            end else if (cnt == CW'(STABLE_CYCLES - 1))
                flip = 1'b1;
            else begin
                state_d = DB_PEND;
                cnt_d   = cnt + CW'(1);
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= DB_IDLE;
            cnt   <= '0;
            out   <= RESET_LEVEL;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            out   <= out ^ flip;
        end
    assign busy = state == DB_PEND;
`ifdef CTRL_DEBOUNCE_PULSE_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= flip & ~out;
            fall <= flip & out;
        end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule
